// File: rtl/board_arb_pkg.sv
// Shared types and constants for the board RAM arbiter.
package board_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_MH = 2'd1,
        GNT_MP = 2'd2
    } arb_state_t;

    localparam logic REQ_MH = 1'b0;
    localparam logic REQ_MP = 1'b1;

    localparam int unsigned DEFAULT_MAX_BURST = 16;

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating count of access cycles within the current grant; limit flags
// that the owner has used (or is now using) its last allowed access.
module arb_burst_counter
    import board_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic limit
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Looks ahead at the current access so the handover lands on the edge
    // that ends the MAX_BURST-th access, not one access later.
    always_comb begin
        limit = (cnt_q == MAX_V) || (inc && (cnt_q == MAX_M1));
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// Request/grant arbiter for the single-port board RAM (memory handler vs move planner).
// Define ARB_ROUND_ROBIN_EN to break IDLE ties by last grant instead of fixed MH priority.
module board_ram_arbiter
    import board_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mh_req,
    input  logic              mh_lock,
    input  logic              mh_we,
    input  logic [ADDR_W-1:0] mh_addr,
    input  logic [DATA_W-1:0] mh_wdata,
    output logic              mh_gnt,
    output logic              mh_rvalid,
    input  logic              mp_req,
    input  logic [ADDR_W-1:0] mp_addr,
    output logic              mp_gnt,
    output logic              mp_rvalid,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we
);

    arb_state_t state_q, state_n;
    logic       mh_acc, mp_acc;
    logic       burst_limit;
    logic       tie_to_mh;

    always_comb begin
        mh_gnt = (state_q == GNT_MH);
        mp_gnt = (state_q == GNT_MP);
        mh_acc = mh_gnt && mh_req;
        mp_acc = mp_gnt && mp_req;
    end

    always_comb begin
        ram_a  = '0;
        ram_d  = '0;
        ram_we = 1'b0;
        if (mh_acc) begin
            ram_a  = mh_addr;
            ram_d  = mh_wdata;
            ram_we = mh_we;
        end else if (mp_acc) begin
            ram_a  = mp_addr;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= REQ_MP;
        end else if (state_n == GNT_MH) begin
            last_q <= REQ_MH;
        end else if (state_n == GNT_MP) begin
            last_q <= REQ_MP;
        end
    end

    always_comb begin
        tie_to_mh = (last_q == REQ_MP);
    end
`else
    always_comb begin
        tie_to_mh = 1'b1;
    end
`endif

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (mh_req && mp_req) begin
                    state_n = tie_to_mh ? GNT_MH : GNT_MP;
                end else if (mh_req) begin
                    state_n = GNT_MH;
                end else if (mp_req) begin
                    state_n = GNT_MP;
                end
            end
            GNT_MH: begin
                if (!mh_req) begin
                    state_n = mp_req ? GNT_MP : IDLE;
                end else if (burst_limit && mp_req && !mh_lock) begin
                    state_n = GNT_MP;
                end
            end
            GNT_MP: begin
                if (!mp_req) begin
                    state_n = mh_req ? GNT_MH : IDLE;
                end else if (burst_limit && mh_req) begin
                    state_n = GNT_MH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mh_rvalid <= 1'b0;
            mp_rvalid <= 1'b0;
        end else begin
            state_q   <= state_n;
            mh_rvalid <= mh_acc && !mh_we;
            mp_rvalid <= mp_acc;
        end
    end

    arb_burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst (
        .clk   (clk),
        .rst   (rst),
        .clear (state_n != state_q),
        .inc   (mh_acc || mp_acc),
        .limit (burst_limit)
    );

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Self-checking bench for board_ram_arbiter with a behavioural RAM and reference model.
module tb_board_ram_arbiter;

    localparam int MAXB = 16;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mh_req, mh_lock, mh_we;
    logic [15:0] mh_addr;
    logic [7:0]  mh_wdata;
    logic        mh_gnt, mh_rvalid;
    logic        mp_req;
    logic [15:0] mp_addr;
    logic        mp_gnt, mp_rvalid;
    logic [15:0] ram_a;
    logic [7:0]  ram_d;
    logic        ram_we;
    logic [7:0]  ram_q;

    int errors = 0;
    int checks = 0;

    // model state: owner 0 none, 1 MH, 2 MP
    int own, burst, last, mh_pend, mp_pend;
    bit exp_mh_rv, exp_mp_rv;
    logic [7:0] exp_q;
    logic [7:0] model_mem [int];
    int we_cnt, we_mp_cnt;

    always #5 clk = ~clk;

    board_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .mh_req(mh_req), .mh_lock(mh_lock), .mh_we(mh_we), .mh_addr(mh_addr),
        .mh_wdata(mh_wdata), .mh_gnt(mh_gnt), .mh_rvalid(mh_rvalid),
        .mp_req(mp_req), .mp_addr(mp_addr), .mp_gnt(mp_gnt), .mp_rvalid(mp_rvalid),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we)
    );

    logic [7:0] mem [0:65535];
    initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_d;
        ram_q <= mem[ram_a];
    end

    task automatic model_reset();
        own = 0; burst = 0; last = 2; mh_pend = 0; mp_pend = 0;
        exp_mh_rv = 1'b0; exp_mp_rv = 1'b0;
    endtask

    function automatic logic [7:0] mread(input logic [15:0] a);
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : 8'h00;
    endfunction

    // One clock cycle, called and returning at a falling edge.
    task automatic step();
        bit mh_acc, mp_acc;
        logic [15:0] ea;
        logic [7:0] ed;
        bit ewe;
        int b, nxt;
        mh_req = (mh_pend > 0);
        mp_req = (mp_pend > 0);
        #1;
        mh_acc = (own == 1) && mh_req;
        mp_acc = (own == 2) && mp_req;
        ea  = mh_acc ? mh_addr : (mp_acc ? mp_addr : 16'h0000);
        ed  = mh_acc ? mh_wdata : 8'h00;
        ewe = mh_acc && mh_we;
        checks++;
        if ({ram_a, ram_d, ram_we} !== {ea, ed, ewe}) begin
            errors++;
            $display("FAIL ram_bus t=%0t a/d/we=%h/%h/%b expected %h/%h/%b", $time, ram_a, ram_d, ram_we, ea, ed, ewe);
        end
        if (ram_we) we_cnt++;
        if (ram_we && mp_gnt) we_mp_cnt++;
        @(posedge clk);
        exp_mh_rv = mh_acc && !mh_we;
        exp_mp_rv = mp_acc;
        if (mh_acc) exp_q = mread(mh_addr);
        else if (mp_acc) exp_q = mread(mp_addr);
        if (ewe) model_mem[int'(mh_addr)] = mh_wdata;
        b = burst + ((mh_acc || mp_acc) ? 1 : 0);
        if (b > MAXB) b = MAXB;
        nxt = own;
        if (own == 0) begin
            if (mh_req && mp_req) nxt = RR ? ((last == 2) ? 1 : 2) : 1;
            else if (mh_req) nxt = 1;
            else if (mp_req) nxt = 2;
        end else if (own == 1) begin
            if (!mh_req) nxt = mp_req ? 2 : 0;
            else if (b >= MAXB && mp_req && !mh_lock) nxt = 2;
        end else begin
            if (!mp_req) nxt = mh_req ? 1 : 0;
            else if (b >= MAXB && mh_req) nxt = 1;
        end
        burst = (nxt != own) ? 0 : b;
        if (nxt != 0) last = nxt;
        own = nxt;
        if (mh_acc) mh_pend--;
        if (mp_acc) mp_pend--;
        #1;
        checks++;
        if ({mh_gnt, mp_gnt, mh_rvalid, mp_rvalid} !== {own == 1, own == 2, exp_mh_rv, exp_mp_rv}) begin
            errors++;
            $display("FAIL grant_rvalid t=%0t gnt mh/mp=%b%b rv=%b%b expected %b%b %b%b", $time,
                     mh_gnt, mp_gnt, mh_rvalid, mp_rvalid, own == 1, own == 2, exp_mh_rv, exp_mp_rv);
        end
        if (exp_mh_rv || exp_mp_rv) begin
            checks++;
            if (ram_q !== exp_q) begin
                errors++;
                $display("FAIL read_data t=%0t ram_q=%h expected %h", $time, ram_q, exp_q);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        mh_pend = 0; mp_pend = 0;
        repeat (3) step();
        checks++;
        if ({mh_gnt, mp_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL drain_idle gnt=%b%b expected 00", mh_gnt, mp_gnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mh_req = 1'b1; mp_req = 1'b1; mh_we = 1'b1; mh_lock = 1'b0;
        mh_addr = 16'h1234; mh_wdata = 8'h77; mp_addr = 16'h4321;
        repeat (3) @(negedge clk);
        checks++;
        if ({mh_gnt, mp_gnt, mh_rvalid, mp_rvalid, ram_a, ram_d, ram_we} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b%b rv=%b%b a=%h d=%h we=%b expected all 0",
                     mh_gnt, mp_gnt, mh_rvalid, mp_rvalid, ram_a, ram_d, ram_we);
        end
        mh_req = 1'b0; mp_req = 1'b0; mh_we = 1'b0;
        model_reset();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mp_read();
        mem[16'h0042] = 8'h5A;
        model_mem[32'h42] = 8'h5A;
        mp_addr = 16'h0042;
        mp_pend = 1;
        step();
        checks++;
        if (mp_gnt !== 1'b1) begin
            errors++; $display("FAIL mp_grant_latency mp_gnt=%b expected 1", mp_gnt);
        end
        step();
        checks++;
        if ({mp_rvalid, ram_q} !== {1'b1, 8'h5A}) begin
            errors++; $display("FAIL mp_read_data rvalid=%b q=%h expected 1 5a", mp_rvalid, ram_q);
        end
        drain();
    endtask

    task automatic test_tie();
        mh_we = 1'b0; mh_addr = 16'h0010; mp_addr = 16'h0020;
        mh_pend = 1; mp_pend = 1;
        step();
        checks++;
        if ({mh_gnt, mp_gnt} !== 2'b10) begin
            errors++; $display("FAIL first_tie gnt=%b%b expected 10", mh_gnt, mp_gnt);
        end
        mp_pend = 0;
        repeat (3) step();
        mh_pend = 1; mp_pend = 1;
        step();
        checks++;
        if ({mh_gnt, mp_gnt} !== (RR ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL second_tie gnt=%b%b expected %b", mh_gnt, mp_gnt, RR ? 2'b01 : 2'b10);
        end
        repeat (4) step();
        drain();
    endtask

    task automatic test_preempt();
        int mp_acc_cnt = 0;
        bit seen_mh = 1'b0, regrant = 1'b0;
        mh_we = 1'b0; mh_lock = 1'b0;
        mp_pend = 20;
        for (int i = 0; i < 80 && !regrant; i++) begin
            if (i == 3) mh_pend = 2;
            mp_addr = 16'h0300 + 16'(i);
            mh_addr = 16'h0400 + 16'(i);
            if (!seen_mh && mp_gnt && mp_pend > 0) mp_acc_cnt++;
            step();
            if (!seen_mh && mh_gnt) seen_mh = 1'b1;
            else if (seen_mh && mp_gnt) regrant = 1'b1;
        end
        checks++;
        if (mp_acc_cnt != MAXB) begin
            errors++; $display("FAIL burst_handover mp_accesses=%0d expected %0d", mp_acc_cnt, MAXB);
        end
        checks++;
        if (!regrant) begin
            errors++; $display("FAIL mp_regrant regranted=0 expected 1 (timeout)");
        end
        drain();
    endtask

    task automatic test_lock();
        int rel_idx = -1, gnt_idx = -1;
        mh_lock = 1'b1;
        mh_pend = 30;
        for (int i = 0; i < 100; i++) begin
            if (i == 2) mp_pend = 3;
            if (rel_idx < 0 && mh_pend == 0) rel_idx = i;
            mh_we = (i % 2 == 1);
            mh_wdata = 8'($urandom);
            mh_addr = 16'h0200 + 16'(i / 2);
            mp_addr = 16'h0200 + 16'($urandom_range(0, 15));
            step();
            if (mp_gnt) begin gnt_idx = i; break; end
        end
        checks++;
        if (rel_idx < 0 || gnt_idx != rel_idx) begin
            errors++; $display("FAIL lock_release mp_gnt_cycle=%0d expected %0d", gnt_idx, rel_idx);
        end
        mh_lock = 1'b0;
        drain();
    endtask

    task automatic test_write_read();
        bit got = 1'b0;
        we_cnt = 0;
        mh_we = 1'b1; mh_addr = 16'h0100; mh_wdata = 8'hA5;
        mh_pend = 1;
        repeat (3) step();
        mh_we = 1'b0;
        mp_addr = 16'h0100;
        mp_pend = 1;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (mp_rvalid) begin
                got = 1'b1;
                checks++;
                if (ram_q !== 8'hA5) begin
                    errors++; $display("FAIL write_then_read q=%h expected a5", ram_q);
                end
            end
        end
        checks++;
        if (!got || we_cnt != 1) begin
            errors++; $display("FAIL write_strobe got_read=%0d we_cycles=%0d expected 1 1", got, we_cnt);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        mp_addr = 16'h0042;
        mp_pend = 5;
        for (int i = 0; i < 5 && own != 2; i++) step();
        // MP owns the RAM and its read is on the bus right now
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({mp_gnt, mp_rvalid, ram_a, ram_we} !== 19'd0) begin
            errors++; $display("FAIL reset_mid gnt=%b rv=%b a=%h we=%b expected 0", mp_gnt, mp_rvalid, ram_a, ram_we);
        end
        @(posedge clk); #1;
        checks++;
        if (mp_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_rvalid rvalid=%b expected 0", mp_rvalid);
        end
        model_reset();
        mh_req = 1'b0; mp_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mh_pend = 1; mp_pend = 1;
        step();
        checks++;
        if ({mh_gnt, mp_gnt} !== 2'b10) begin
            errors++; $display("FAIL tie_after_reset gnt=%b%b expected 10", mh_gnt, mp_gnt);
        end
        repeat (4) step();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if (mh_pend == 0 && $urandom_range(0, 3) == 0) begin
                mh_pend = $urandom_range(1, 20);
                mh_lock = ($urandom_range(0, 3) == 0);
            end
            if (mp_pend == 0 && $urandom_range(0, 3) == 0) mp_pend = $urandom_range(1, 24);
            if (own != 2 && mp_pend > 0 && $urandom_range(0, 19) == 0) mp_pend = 0;
            if (own != 1 && mh_pend > 0 && $urandom_range(0, 19) == 0) mh_pend = 0;
            mh_we = $urandom_range(0, 1);
            mh_wdata = 8'($urandom);
            mh_addr = {8'h05, 8'($urandom_range(0, 31))};
            mp_addr = {8'h05, 8'($urandom_range(0, 31))};
            step();
        end
        mh_lock = 1'b0;
        drain();
    endtask

    initial begin
        we_mp_cnt = 0; we_cnt = 0;
        mh_pend = 0; mp_pend = 0;
        @(negedge clk);
        test_reset();
        test_mp_read();
        test_tie();
        test_preempt();
        test_lock();
        test_write_read();
        test_reset_mid();
        test_random();
        checks++;
        if (we_mp_cnt != 0) begin
            errors++; $display("FAIL we_during_mp count=%0d expected 0", we_mp_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_ram_arbiter.md
# board_ram_arbiter

Arbitrates the single-port board RAM (`ram_single`, 1-cycle synchronous read) between the memory handler (read-modify-write board updates) and the move planner (read-only board scan). Replaces the static `idle`-driven address mux in the top level with a request/grant handshake, a bounded hold time, and a lock for atomic RMW sequences. Sits between the two requesters and the RAM instance.

## Interface
- `ADDR_W`, 16, RAM address width
- `DATA_W`, 8, RAM data width
- `MAX_BURST`, 16, access cycles a requester may hold the RAM while the other waits (≥2)

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `mh_req`  in  1  memory handler requests access
- `mh_lock`  in  1  memory handler forbids preemption while granted
- `mh_we`  in  1  memory handler write strobe (valid with access)
- `mh_addr`  in  ADDR_W  memory handler address
- `mh_wdata`  in  DATA_W  memory handler write data
- `mh_gnt`  out  1  memory handler owns RAM
- `mh_rvalid`  out  1  `ram_q` holds memory handler read data
- `mp_req`  in  1  move planner requests access (reads only)
- `mp_addr`  in  ADDR_W  move planner address
- `mp_gnt`  out  1  move planner owns RAM
- `mp_rvalid`  out  1  `ram_q` holds move planner read data
- `ram_a`  out  ADDR_W  RAM address
- `ram_d`  out  DATA_W  RAM write data
- `ram_we`  out  1  RAM write enable

## Operation
- States: `IDLE`, `GNT_MH`, `GNT_MP`. `mh_gnt`/`mp_gnt` are registered decodes of state; never both high.
- Access cycle: cycle with `x_gnt && x_req`. Only access cycles drive the RAM: `ram_a = x_addr`, `ram_d = mh_wdata`, `ram_we = mh_gnt && mh_req && mh_we` (combinational). MP never writes.
- Non-access cycles: `ram_a = 0`, `ram_d = 0`, `ram_we = 0`.
- `IDLE`: single request → grant it. Both → MH (fixed priority; see Configuration).
- `GNT_x`, `x_req` low → if other requests go to `GNT_other`, else `IDLE`.
- Burst counter: cleared on every grant change; increments per access cycle, saturates at `MAX_BURST`. When count = `MAX_BURST` and other requests and not (`GNT_MH` && `mh_lock`) → switch to `GNT_other`. Preempted requester keeps `req` high and is regranted later, counter restarting.
- `mh_lock` high in `GNT_MH`: no preemption regardless of count; released only by `mh_req` low. `mh_lock` ignored outside `GNT_MH`.
- Read data: `x_rvalid` registered, high one cycle after an access cycle with write low; `ram_q` is valid that same cycle.

## Timing
- Reset: state `IDLE`, counter 0, last-grant = MP; `mh_gnt`, `mp_gnt`, `mh_rvalid`, `mp_rvalid` = 0; `ram_a`/`ram_d`/`ram_we` = 0.
- Grant latency: `req` high in cycle t (from `IDLE`) → `gnt` high cycle t+1; first access t+1; read data/`rvalid` t+2.
- Handover: old `gnt` falls and new `gnt` rises on the same edge; no dead cycle, no overlap.
- Release: `req` low in cycle t → `gnt` low at t+1. Requester must not drop `req` for an access it still needs.
- `rvalid` for the last access of a grant still asserts the cycle after the handover.
- Simultaneous release by owner and request by other → other granted next edge.
- `req` deasserted by a waiting requester before grant → no grant, no side effect.
- Reset mid-grant: immediate return to reset values; an in-flight `rvalid` is discarded; an in-flight write completes only if its edge preceded reset.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: in `IDLE` with both requesting, grant goes to the requester not granted last (last-grant register, reset = MP, so MH wins first). Preemption unchanged.
- Undefined: fixed priority, MH always wins ties; last-grant register not implemented.

## Structure
- Package `board_arb_pkg`: state enum (`IDLE`, `GNT_MH`, `GNT_MP`), requester id constants (`REQ_MH`, `REQ_MP`), default `MAX_BURST`.
- One sub-module `arb_burst_counter`: clear, increment-on-access, saturating at `MAX_BURST`, `limit` flag; width `$clog2(MAX_BURST+1)`.

## Test plan
- Reset then MP reads addr 0x0042 holding 0x5A → `mp_gnt` at t+1, `mp_rvalid` and `ram_q`=0x5A at t+2; all outputs 0 during reset.
- Both request in same cycle from `IDLE` → `mh_gnt`; with `ARB_ROUND_ROBIN_EN`, second tie after MH release → `mp_gnt`.
- MP holds 20 reads, MH requests at read 3, `MAX_BURST`=16 → handover after 16th MP access cycle, MP regranted after MH releases.
- MH RMW with `mh_lock` high for 30 cycles while MP requests → no preemption; `mp_gnt` the cycle after `mh_req` falls.
- MH write 0xA5 to 0x0100 then MP read 0x0100 → `ram_we` one cycle, MP read returns 0xA5; `ram_we` never high during `mp_gnt`.
- `rst` low during `GNT_MP` with read in flight → `mp_gnt`, `mp_rvalid` low immediately; after release first tie goes to MH.
